// File: rtl/stream_stage_mapper.sv
// Ping-pong frame buffer that reorders a complex sample stream: passthrough, two-bit index
// swap, or full bit-reversal, selected per frame by the mode seen on its first beat.
module stream_stage_mapper #(
    parameter int unsigned data_width = 8,
    parameter int unsigned log2_n     = 5,
    parameter int unsigned swap_lo    = 0,
    parameter int unsigned swap_hi    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            mode,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [data_width-1:0] input_data_real,
    input  logic [data_width-1:0] input_data_imag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [data_width-1:0] output_data_real,
    output logic [data_width-1:0] output_data_imag,
    output logic                  out_last
);

    localparam int unsigned           Npts    = 1 << log2_n;
    localparam logic [log2_n-1:0]     LastIdx = {log2_n{1'b1}};

    logic [data_width-1:0] r_mem_re [2][Npts];
    logic [data_width-1:0] r_mem_im [2][Npts];

    logic [1:0]        r_full;
    logic [1:0]        r_mode [2];
    logic [log2_n-1:0] r_wr_cnt;
    logic [log2_n-1:0] r_rd_cnt;
    logic              r_wr_bank;
    logic              r_rd_bank;

    logic              w_in_fire;
    logic              w_out_fire;
    logic [log2_n-1:0] w_rd_addr;

    // Reserved mode 11 falls through to passthrough.
    function automatic logic [log2_n-1:0] f_permute(input logic [1:0]        m,
                                                    input logic [log2_n-1:0] k);
        logic [log2_n-1:0] r;
        r = k;
        case (m)
            2'b01: begin
                r[swap_lo] = k[swap_hi];
                r[swap_hi] = k[swap_lo];
            end
            2'b10: begin
                for (int unsigned i = 0; i < log2_n; i++) begin
                    r[i] = k[log2_n-1-i];
                end
            end
            default: r = k;
        endcase
        return r;
    endfunction

    assign in_ready   = ~r_full[r_wr_bank];
    assign out_valid  = r_full[r_rd_bank];
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;
    assign w_rd_addr  = f_permute(r_mode[r_rd_bank], r_rd_cnt);

    assign output_data_real = r_mem_re[r_rd_bank][w_rd_addr];
    assign output_data_imag = r_mem_im[r_rd_bank][w_rd_addr];
    assign out_last         = out_valid & (r_rd_cnt == LastIdx);

    always_ff @(posedge clk) begin
        if (w_in_fire) begin
            r_mem_re[r_wr_bank][r_wr_cnt] <= input_data_real;
            r_mem_im[r_wr_bank][r_wr_cnt] <= input_data_imag;
        end
    end

    // The write bank is never full and the read bank is always full while active, so the two
    // full-flag updates below always target different banks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full    <= 2'b00;
            r_mode[0] <= 2'b00;
            r_mode[1] <= 2'b00;
            r_wr_cnt  <= '0;
            r_rd_cnt  <= '0;
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
        end else begin
            if (w_in_fire) begin
                if (r_wr_cnt == '0) begin
                    r_mode[r_wr_bank] <= mode;
                end
                if (r_wr_cnt == LastIdx) begin
                    r_full[r_wr_bank] <= 1'b1;
                    r_wr_cnt          <= '0;
                    r_wr_bank         <= ~r_wr_bank;
                end else begin
                    r_wr_cnt <= r_wr_cnt + 1'b1;
                end
            end
            if (w_out_fire) begin
                if (r_rd_cnt == LastIdx) begin
                    r_full[r_rd_bank] <= 1'b0;
                    r_rd_cnt          <= '0;
                    r_rd_bank         <= ~r_rd_bank;
                end else begin
                    r_rd_cnt <= r_rd_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_stream_stage_mapper.sv
// Bench for stream_stage_mapper: directed frame scenarios plus random traffic, all checked
// against a frame-level queue model of the reorder buffer.
module tb_stream_stage_mapper;

    localparam int unsigned DW      = 8;
    localparam int unsigned LOG2N   = 5;
    localparam int unsigned N       = 32;
    localparam int unsigned SWAP_LO = 0;
    localparam int unsigned SWAP_HI = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    mode;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] input_data_real;
    logic [DW-1:0] input_data_imag;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] output_data_real;
    logic [DW-1:0] output_data_imag;
    logic          out_last;

    stream_stage_mapper #(
        .data_width (DW),
        .log2_n     (LOG2N),
        .swap_lo    (SWAP_LO),
        .swap_hi    (SWAP_HI)
    ) u_dut (
        .clk              (clk),
        .rst              (rst),
        .mode             (mode),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .input_data_real  (input_data_real),
        .input_data_imag  (input_data_imag),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .output_data_real (output_data_real),
        .output_data_imag (output_data_imag),
        .out_last         (out_last)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: expected outputs of every completed, undrained frame, in output order.
    // Entry encoding: real | imag << 8 | last << 16.
    int unsigned exp_q[$];
    int unsigned wbuf_re[N];
    int unsigned wbuf_im[N];
    int unsigned wcnt;
    int unsigned wmode;

    logic        obs_in_ready;
    logic        obs_out_valid;
    logic        obs_emit;
    int unsigned obs_real;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned perm(input int unsigned m, input int unsigned k);
        int unsigned bl, bh, r, t;
        if (m == 1) begin
            bl = (k / (2 ** SWAP_LO)) % 2;
            bh = (k / (2 ** SWAP_HI)) % 2;
            return k - bl * (2 ** SWAP_LO) - bh * (2 ** SWAP_HI)
                     + bh * (2 ** SWAP_LO) + bl * (2 ** SWAP_HI);
        end else if (m == 2) begin
            r = 0;
            t = k;
            for (int i = 0; i < int'(LOG2N); i++) begin
                r = r * 2 + t % 2;
                t = t / 2;
            end
            return r;
        end
        return k;
    endfunction

    task automatic step(input logic iv, input logic [1:0] md, input logic [DW-1:0] re,
                        input logic [DW-1:0] im, input logic ordy);
        int unsigned fc, e, idx;
        logic        acc;
        @(negedge clk);
        in_valid        = iv;
        mode            = md;
        input_data_real = re;
        input_data_imag = im;
        out_ready       = ordy;
        #1;
        fc = (exp_q.size() + N - 1) / N;
        check("in_ready", 32'(in_ready), 32'(fc < 2));
        check("out_valid", 32'(out_valid), 32'(fc >= 1));
        if (fc >= 1) begin
            e = exp_q[0];
            check("out_real", 32'(output_data_real), e % 256);
            check("out_imag", 32'(output_data_imag), (e / 256) % 256);
            check("out_last", 32'(out_last), (e / 65536) % 2);
        end else begin
            check("out_last_idle", 32'(out_last), 32'(0));
        end
        obs_in_ready  = in_ready;
        obs_out_valid = out_valid;
        obs_real      = 32'(output_data_real);
        acc           = iv & in_ready;
        obs_emit      = out_valid & ordy;
        @(posedge clk);
        if (obs_emit && exp_q.size() > 0) begin
            void'(exp_q.pop_front());
        end
        if (acc) begin
            if (wcnt == 0) wmode = 32'(md);
            wbuf_re[wcnt] = 32'(re);
            wbuf_im[wcnt] = 32'(im);
            wcnt++;
            if (wcnt == N) begin
                for (int unsigned j = 0; j < N; j++) begin
                    idx = perm(wmode, j);
                    exp_q.push_back(wbuf_re[idx] + wbuf_im[idx] * 256 +
                                    ((j == N - 1) ? 65536 : 0));
                end
                wcnt = 0;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_in_ready", 32'(in_ready), 32'(1));
        check("rst_out_last", 32'(out_last), 32'(0));
        exp_q.delete();
        wcnt = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drain(input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b0, 2'b00, 8'h00, 8'h00, 1'b1);
    endtask

    int unsigned seen[8];
    int unsigned want_swap[8];
    int          n_low, n_out, first_out;

    initial begin
        rst = 1'b1; mode = 2'b00; in_valid = 1'b0; out_ready = 1'b0;
        input_data_real = '0; input_data_imag = '0;
        wcnt = 0; wmode = 0;
        want_swap = '{0, 4, 2, 6, 1, 5, 3, 7};
        repeat (2) @(posedge clk);
        do_reset();

        // Swap mode, ramp data.
        for (int k = 0; k < int'(N); k++) step(1'b1, 2'b01, 8'(k), 8'(255 - k), 1'b0);
        for (int k = 0; k < int'(N); k++) begin
            step(1'b0, 2'b00, 8'h00, 8'h00, 1'b1);
            if (k < 8) seen[k] = obs_real;
        end
        for (int k = 0; k < 8; k++) check("swap_seq", seen[k], want_swap[k]);

        // Bit-reversal mode and its one-cycle latency.
        for (int k = 0; k < int'(N); k++) step(1'b1, 2'b10, 8'(k), 8'(255 - k), 1'b1);
        check("br_no_early_valid", 32'(obs_out_valid), 32'(0));
        step(1'b0, 2'b00, 8'h00, 8'h00, 1'b1);
        check("br_latency", 32'(obs_out_valid), 32'(1));
        check("br_first", obs_real, 32'(0));
        step(1'b0, 2'b00, 8'h00, 8'h00, 1'b1);
        check("br_second", obs_real, 32'(16));
        drain(N);

        // Streaming throughput: three back-to-back frames.
        do_reset();
        n_low = 0; n_out = 0; first_out = -1;
        for (int c = 0; c < 128; c++) begin
            step(c < 96, 2'b10, 8'($urandom), 8'($urandom), 1'b1);
            if (!obs_in_ready) n_low++;
            if (obs_emit) begin
                n_out++;
                if (first_out < 0) first_out = c;
            end
        end
        check("tp_in_ready_lows", 32'(n_low), 32'(0));
        check("tp_outputs", 32'(n_out), 32'(96));
        check("tp_first_out", 32'(first_out), 32'(32));

        // Backpressure: both banks fill, then drain one.
        do_reset();
        for (int c = 0; c < 64; c++) step(1'b1, 2'b01, 8'($urandom), 8'($urandom), 1'b0);
        step(1'b1, 2'b01, 8'h55, 8'haa, 1'b0);
        check("bp_in_ready_low", 32'(obs_in_ready), 32'(0));
        for (int c = 0; c < 32; c++) step(1'b0, 2'b00, 8'h00, 8'h00, 1'b1);
        check("bp_still_low_at_32nd", 32'(obs_in_ready), 32'(0));
        step(1'b0, 2'b00, 8'h00, 8'h00, 1'b0);
        check("bp_in_ready_back", 32'(obs_in_ready), 32'(1));
        drain(N + 1);

        // Mid-frame mode change is ignored until the next frame.
        do_reset();
        for (int c = 0; c < 64; c++) begin
            step(1'b1, (c < 5) ? 2'b01 : 2'b10, 8'(c), 8'(c + 100), 1'b1);
        end
        drain(2 * N);

        // Reset during read at output beat 10.
        for (int k = 0; k < int'(N); k++) step(1'b1, 2'b10, 8'($urandom), 8'($urandom), 1'b0);
        for (int k = 0; k < 10; k++) step(1'b0, 2'b00, 8'h00, 8'h00, 1'b1);
        do_reset();
        for (int k = 0; k < int'(N); k++) step(1'b1, 2'b00, 8'(k * 3), 8'(k), 1'b0);
        drain(N + 1);

        // Random traffic, including reserved mode and occasional resets.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 999) == 0) do_reset();
            step($urandom_range(0, 3) != 0, 2'($urandom), 8'($urandom), 8'($urandom),
                 $urandom_range(0, 2) != 0);
        end
        drain(2 * N + 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/stream_stage_mapper.md
STREAM_STAGE_MAPPER -- requirements
Module: stream_stage_mapper

Interface
REQ-001 SHALL have parameter data_width, default 8, meaning bit width of each real and each imaginary sample.
REQ-002 SHALL have parameter log2_n, default 5, meaning log2 of frame length N (N = 2^log2_n points).
REQ-003 SHALL have parameters swap_lo, default 0, and swap_hi, default 2, meaning the index bit positions exchanged in swap mode; legal range 0..log2_n-1, swap_lo < swap_hi.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all state on rising edge.
REQ-005 SHALL have port rst, input, 1, meaning asynchronous, active-high reset.
REQ-006 SHALL have port mode, input, 2, meaning permutation select: 00 passthrough, 01 swap bits swap_lo/swap_hi, 10 full bit-reversal, 11 reserved and treated as 00.
REQ-007 SHALL have ports in_valid (input, 1) and in_ready (output, 1), meaning the input handshake.
REQ-008 SHALL have ports input_data_real and input_data_imag, input, data_width each, meaning one complex sample per accepted beat.
REQ-009 SHALL have ports out_valid (output, 1) and out_ready (input, 1), meaning the output handshake.
REQ-010 SHALL have ports output_data_real and output_data_imag, output, data_width each, meaning the permuted sample.
REQ-011 SHALL have port out_last, output, 1, meaning high with the final (N-th) output beat of a frame.

Function
REQ-012 SHALL transfer a beat only when valid and ready are both high on a rising clk edge; data is not modified, only reordered.
REQ-013 SHALL hold two banks (ping-pong) of N complex entries, each with a full flag and a captured mode.
REQ-014 SHALL write accepted input beats in natural order, at address = write counter 0..N-1, into the current write bank.
REQ-015 SHALL capture mode on the first accepted beat (counter 0) of each frame into that bank; changes later in the frame are ignored.
REQ-016 SHALL, on acceptance of beat N-1, set that bank's full flag, wrap the write counter to 0 and toggle the write bank.
REQ-017 SHALL drive in_ready = NOT full(write bank), from registered state only, with no combinational path from out_ready.
REQ-018 SHALL drive out_valid = full(read bank); output data is read combinationally from the read bank at address P(read counter).
REQ-019 SHALL define P(k) for the captured mode as: 00 gives k; 01 gives k with bits swap_lo and swap_hi exchanged; 10 gives k with bits reversed over log2_n bits.
REQ-020 SHALL, on each output handshake, increment the read counter; on handshake of beat N-1, assert out_last, clear the full flag, wrap the counter to 0 and toggle the read bank.
REQ-021 SHALL allow write of one bank and read of the other in the same cycle.
REQ-022 SHALL make a bank freed at edge t accept writes from edge t+1, giving sustained throughput of 1 beat/cycle with out_ready held high.
REQ-023 SHALL set latency from the last input handshake of a frame to first out_valid at 1 cycle.
REQ-024 SHALL, with both banks full, hold in_ready low until the read side frees a bank; out_ready low SHALL hold output data and the read counter stable.

Reset
REQ-025 SHALL, while rst is high, asynchronously clear both full flags, both counters and both bank pointers to 0, and hold captured modes at 00.
REQ-026 SHALL produce the following reset output values: out_valid 0, out_last 0, in_ready 1; bank contents are not reset and are don't-care.
REQ-027 SHALL discard any partial frame on reset, whether mid-write or mid-read; the first accepted beat after reset is beat 0 of a new frame.

Verification
REQ-028 SHALL be checked for swap mode: N=32, mode=01, real=k, imag=255-k for k=0..31 -> output real sequence 0,4,2,6,1,5,3,7,8,12,10,14,9,13,11,15,... through 31, imag=255-real, out_last only on the 32nd beat.
REQ-029 SHALL be checked for bit-reversal mode: mode=10, real=k -> output 0,16,8,24,4,20,12,28,...,31; first out_valid 1 cycle after input beat 31.
REQ-030 SHALL be checked for streaming throughput: three back-to-back frames with in_valid=1 and out_ready=1 -> in_ready never deasserts after reset, and 96 outputs appear on consecutive cycles starting at cycle 32.
REQ-031 SHALL be checked for backpressure: out_ready=0, two full frames written -> in_ready=0 from cycle 64; raising out_ready -> in_ready returns to 1 the cycle after the 32nd output handshake.
REQ-032 SHALL be checked for mid-frame mode change: mode=01 at beat 0 switched to 10 at beat 5 -> the whole frame is output in swap order, and the next frame uses 10.
REQ-033 SHALL be checked for reset during read: rst pulsed at output beat 10 -> out_valid=0 immediately, in_ready=1; a new frame then outputs correctly from beat 0.
